// File: rtl/pu_ld_obuf_beat_sequencer_if.sv
// Walker-side and OBUF-side handshake bundle for the OBUF load beat sequencer.
// The master modport is the sequencer view; slave is the surrounding
// walker / OBUF read port / load stream FIFO view.
interface pu_ld_obuf_beat_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BEATS  = 4,
  parameter int BEAT_ID_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
);
  logic                            addr_in_valid;
  logic [ADDR_WIDTH-1:0]           addr_in;
  logic                            addr_in_ready;
  logic                            mem_req;
  logic [ADDR_WIDTH+BEAT_ID_W-1:0] mem_addr;
  logic                            mem_last_beat;
  logic                            mem_ready;
  logic                            obuf_ld_stream_write_ready;

  modport master (
    input  addr_in_valid, addr_in, mem_ready, obuf_ld_stream_write_ready,
    output addr_in_ready, mem_req, mem_addr, mem_last_beat
  );

  modport slave (
    output addr_in_valid, addr_in, mem_ready, obuf_ld_stream_write_ready,
    input  addr_in_ready, mem_req, mem_addr, mem_last_beat
  );
endinterface

// File: rtl/pu_ld_obuf_beat_sequencer.sv
// OBUF load request sequencer: expands each walker line address into
// nbeats sub-word requests, mem_addr = {line_addr, beat_id}, for a programmed
// number of line addresses, then pulses done.
module pu_ld_obuf_beat_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_BEATS  = 4,
  parameter int BEAT_ID_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1,
  parameter int BEAT_CNT_W = $clog2(MAX_BEATS + 1),
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BEAT_CNT_W-1:0] cfg_num_beats,
  input  logic [COUNT_W-1:0]    cfg_num_addrs,
  output logic                  busy,
  output logic                  done,
  pu_ld_obuf_beat_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [BEAT_CNT_W-1:0] nbeats;
  logic [COUNT_W-1:0]    naddrs;
  logic [COUNT_W-1:0]    acc_cnt;
  logic [COUNT_W-1:0]    iss_cnt;
  logic [BEAT_ID_W-1:0]  beat_q;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_valid;

  logic                  run;
  logic [BEAT_CNT_W-1:0] nbeats_m1;
  logic [BEAT_CNT_W-1:0] beats_clamped;
  logic                  last_beat;
  logic                  fire;
  logic                  last_fire;
  logic                  in_ready;
  logic                  accept;

  // Request/accept decode; the holding register can be refilled in the same
  // cycle its last beat fires, which is what gives bubble-free line changes.
  always_comb begin
    run           = (state == RUN);
    nbeats_m1     = nbeats - BEAT_CNT_W'(1);
    beats_clamped = cfg_num_beats;
    if (cfg_num_beats == '0 || cfg_num_beats > BEAT_CNT_W'(MAX_BEATS))
      beats_clamped = BEAT_CNT_W'(MAX_BEATS);
    last_beat = cur_valid && (BEAT_CNT_W'(beat_q) == nbeats_m1);
    fire      = run && cur_valid && bus.mem_ready && bus.obuf_ld_stream_write_ready;
    last_fire = fire && last_beat;
    in_ready  = run && (acc_cnt < naddrs) && (!cur_valid || last_fire);
    accept    = bus.addr_in_valid && in_ready;
  end

  assign bus.addr_in_ready = in_ready;
  assign bus.mem_req       = fire;
  assign bus.mem_last_beat = last_beat;
  assign bus.mem_addr      = cur_valid ? {cur_addr, beat_q} : '0;

  // Run control FSM with holding register, beat index and line counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      nbeats    <= '0;
      naddrs    <= '0;
      acc_cnt   <= '0;
      iss_cnt   <= '0;
      beat_q    <= '0;
      cur_addr  <= '0;
      cur_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            nbeats    <= beats_clamped;
            naddrs    <= cfg_num_addrs;
            acc_cnt   <= '0;
            iss_cnt   <= '0;
            beat_q    <= '0;
            cur_valid <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            cur_addr <= bus.addr_in;
            acc_cnt  <= acc_cnt + COUNT_W'(1);
          end
          if (last_fire) begin
            beat_q  <= '0;
            iss_cnt <= iss_cnt + COUNT_W'(1);
          end else if (fire) begin
            beat_q <= beat_q + BEAT_ID_W'(1);
          end
          if (accept)
            cur_valid <= 1'b1;
          else if (last_fire)
            cur_valid <= 1'b0;
          // naddrs==0 finishes immediately; otherwise finish on the final
          // line's last beat so done lands on the very next cycle.
          if (naddrs == '0 || (last_fire && iss_cnt == naddrs - COUNT_W'(1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_ld_obuf_beat_sequencer.sv
// Self-checking bench for pu_ld_obuf_beat_sequencer (MAX_BEATS=4, ADDR_WIDTH=8).
// Reference model tracks accepted lines and fired beats as plain counts.
module tb_pu_ld_obuf_beat_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  cfg_num_beats;
  logic [15:0] cfg_num_addrs;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  pu_ld_obuf_beat_sequencer_if #(.ADDR_WIDTH(8), .MAX_BEATS(4)) bus ();

  pu_ld_obuf_beat_sequencer #(
    .ADDR_WIDTH(8),
    .MAX_BEATS (4),
    .COUNT_W   (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .cfg_num_beats(cfg_num_beats),
    .cfg_num_addrs(cfg_num_addrs),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nb;
    int na;
    int base;
    int extra;
    int stall_at;
    int stall_len;
    int exp_fires;
    int exp_done_cyc;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One run: start, walker feed, per-cycle model comparison, idle check after done.
  task automatic run_seq(input int nb_cfg, input int na, input int base, input int extra,
                         input bit rnd, input int stall_at, input int stall_len,
                         output int n_fires, output int done_cyc,
                         output int first_a, output int last_a);
    int nb, acc, fired, widx, cyc, stall_cnt, done_cnt, phase, completed, beat, e_addr;
    bit cur_v, e_req, e_last, e_air, acc_now;
    int wq[$];
    int aq[$];
    nb = (nb_cfg == 0 || nb_cfg > 4) ? 4 : nb_cfg;
    for (int i = 0; i < na + extra; i++) wq.push_back((base + i) % 256);
    acc = 0; fired = 0; widx = 0; stall_cnt = 0; done_cnt = 0;
    n_fires = 0; done_cyc = -1; first_a = -1; last_a = -1;
    start = 1'b1;
    cfg_num_beats = 3'(nb_cfg);
    cfg_num_addrs = 16'(na);
    @(posedge clk); #1;
    start = 1'b0;
    phase = 1;
    cyc = 1;
    while (1) begin
      bus.addr_in_valid = (widx < wq.size()) && (!rnd || $urandom_range(3) != 0);
      bus.addr_in       = (widx < wq.size()) ? 8'(wq[widx]) : 8'($urandom);
      bus.mem_ready     = !rnd || ($urandom_range(3) != 0);
      if (stall_at >= 0 && fired == stall_at && stall_cnt < stall_len) begin
        bus.obuf_ld_stream_write_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus.obuf_ld_stream_write_ready = !rnd || ($urandom_range(3) != 0);
      end
      if (rnd && $urandom_range(7) == 0) begin
        start = 1'b1;
        cfg_num_beats = 3'($urandom);
        cfg_num_addrs = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      completed = fired / nb;
      beat      = fired % nb;
      cur_v     = (acc > completed);
      e_req     = (phase == 1) && cur_v && bus.mem_ready && bus.obuf_ld_stream_write_ready;
      e_last    = cur_v && (beat == nb - 1);
      e_addr    = cur_v ? (aq[completed] * 4 + beat) : 0;
      e_air     = (phase == 1) && (acc < na) && (!cur_v || (e_req && e_last));
      chk("busy", int'(busy), int'(phase == 1));
      chk("done", int'(done), int'(phase == 2));
      chk("mem_req", int'(bus.mem_req), int'(e_req));
      chk("mem_last_beat", int'(bus.mem_last_beat), int'(e_last));
      chk("mem_addr", int'(bus.mem_addr), e_addr);
      chk("addr_in_ready", int'(bus.addr_in_ready), int'(e_air));
      if (bus.mem_req) begin
        n_fires++;
        if (first_a < 0) first_a = int'(bus.mem_addr);
        last_a = int'(bus.mem_addr);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      acc_now = bus.addr_in_valid && e_air;
      if (phase == 2) begin
        phase = 0;
      end else begin
        if (e_req) fired++;
        if (acc_now) begin
          aq.push_back(wq[widx]);
          widx++;
          acc++;
        end
        if (na == 0 || (e_req && e_last && (fired / nb) == na)) phase = 2;
      end
      @(posedge clk); #1;
      cyc++;
      if (phase == 0) break;
      if (cyc > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout: run nb=%0d na=%0d still busy after %0d cycles", nb_cfg, na, cyc);
        break;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_mem_req", int'(bus.mem_req), 0);
    chk("idle_addr_in_ready", int'(bus.addr_in_ready), 0);
    chk("accepted", widx, na);
    chk("done_pulses", done_cnt, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int nf, dc, fa, la, nb_r, na_r, nf_rst;
    bit acc_seen;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    start = 1'b0;
    cfg_num_beats = '0;
    cfg_num_addrs = '0;
    bus.addr_in_valid = 1'b1;
    bus.addr_in = 8'h33;
    bus.mem_ready = 1'b1;
    bus.obuf_ld_stream_write_ready = 1'b1;

    //           nb na base  ex stall len fires done first  last
    tbl[0] = '{4, 2, 'h10, 0, -1, 0, 8, 10, 'h40,  'h47};
    tbl[1] = '{2, 3, 'h05, 0, -1, 0, 6,  8, 'h14,  'h1D};
    tbl[2] = '{0, 2, 'h20, 0, -1, 0, 8, 10, 'h80,  'h87};
    tbl[3] = '{7, 1, 'h30, 0, -1, 0, 4,  6, 'hC0,  'hC3};
    tbl[4] = '{1, 3, 'h08, 0, -1, 0, 3,  5, 'h20,  'h28};
    tbl[5] = '{4, 2, 'h10, 0,  2, 3, 8, 13, 'h40,  'h47};
    tbl[6] = '{4, 0, 'h00, 0, -1, 0, 0,  2, -1,    -1};
    tbl[7] = '{2, 2, 'h40, 1, -1, 0, 4,  6, 'h100, 'h105};
    tbl[8] = '{3, 2, 'hFF, 0, -1, 0, 6,  8, 'h3FC, 'h002};

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mem_req", int'(bus.mem_req), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_mem_last_beat", int'(bus.mem_last_beat), 0);
    chk("rst_addr_in_ready", int'(bus.addr_in_ready), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.addr_in_valid = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_seq(tbl[i].nb, tbl[i].na, tbl[i].base, tbl[i].extra, 1'b0,
              tbl[i].stall_at, tbl[i].stall_len, nf, dc, fa, la);
      chk($sformatf("tbl%0d_fires", i), nf, tbl[i].exp_fires);
      chk($sformatf("tbl%0d_done_cycle", i), dc, tbl[i].exp_done_cyc);
      chk($sformatf("tbl%0d_first_addr", i), fa, tbl[i].exp_first);
      chk($sformatf("tbl%0d_last_addr", i), la, tbl[i].exp_last);
    end

    // Reset after three beats of a 4x2 run aborts with no done pulse.
    bus.mem_ready = 1'b1;
    bus.obuf_ld_stream_write_ready = 1'b1;
    bus.addr_in_valid = 1'b1;
    bus.addr_in = 8'h10;
    start = 1'b1;
    cfg_num_beats = 3'd4;
    cfg_num_addrs = 16'd2;
    @(posedge clk); #1;
    start = 1'b0;
    nf_rst = 0;
    for (int c = 0; c < 50 && nf_rst < 3; c++) begin
      @(negedge clk);
      acc_seen = bus.addr_in_valid && bus.addr_in_ready;
      if (bus.mem_req) nf_rst++;
      @(posedge clk); #1;
      if (acc_seen) bus.addr_in = 8'h11;
    end
    chk("rst_pre_fires", nf_rst, 3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_mem_req", int'(bus.mem_req), 0);
    chk("midrst_mem_addr", int'(bus.mem_addr), 0);
    chk("midrst_mem_last_beat", int'(bus.mem_last_beat), 0);
    chk("midrst_addr_in_ready", int'(bus.addr_in_ready), 0);
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_done", int'(done), 0);
      chk("midrst_no_req", int'(bus.mem_req), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.addr_in_valid = 1'b0;
    run_seq(4, 2, 'h10, 0, 1'b0, -1, 0, nf, dc, fa, la);
    chk("post_rst_fires", nf, 8);
    chk("post_rst_first_addr", fa, 'h40);
    chk("post_rst_done_cycle", dc, 10);

    // Randomized runs with random readies, walker gaps and stray starts.
    for (int r = 0; r < 25; r++) begin
      nb_r = int'($urandom_range(7));
      na_r = int'($urandom_range(6));
      run_seq(nb_r, na_r, int'($urandom_range(255)), int'($urandom_range(2)), 1'b1,
              -1, 0, nf, dc, fa, la);
      chk("rand_fires", nf, na_r * ((nb_r == 0 || nb_r > 4) ? 4 : nb_r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
